nonce_sweep_controller: RTL

//  Sequences one pipelined SHA-256d miner core through a nonce range per work item.

---
 rtl/nonce_sweep_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nonce_sweep_controller.sv
// Nonce sweep sequencer for one pipelined SHA-256d core: loads a work item, issues one nonce
// per cycle, drains the core pipeline and reports the first golden nonce, exhaustion or abort.
//
// state  | meaning
// IDLE   | waiting for work, work_ready high
// LOAD   | one-cycle core_load pulse with latched midstate / header tail
// SWEEP  | one nonce issued per cycle
// DRAIN  | issue stopped, CORE_LATENCY cycles for in-flight nonces to retire
// REPORT | result held on res_* until res_ready
module nonce_sweep_controller #(
  parameter int CORE_LATENCY = 2,
  parameter int CNT_W        = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_count,
  input  logic         abort,
  output logic         core_load,
  output logic [255:0] core_midstate,
  output logic [95:0]  core_data,
  output logic         core_issue,
  output logic [31:0]  core_nonce,
  input  logic         core_hit,
  input  logic [31:0]  core_hit_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic         res_aborted,
  output logic [31:0]  res_nonce,
  output logic         busy
);

  localparam int DRAIN_W = (CORE_LATENCY < 2) ? 1 : $clog2(CORE_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWEEP,
    DRAIN,
    REPORT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [255:0]       mid_q;
  logic [95:0]        data_q;
  logic [31:0]        next_q;
  logic [CNT_W-1:0]   rem_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               found_q;
  logic               aborted_q;
  logic [31:0]        hit_nonce_q;
  logic               hit_take;
  logic               enter_drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_ready  = 1'b0;
    core_load   = 1'b0;
    core_issue  = 1'b0;
    core_nonce  = '0;
    res_valid   = 1'b0;
    res_found   = 1'b0;
    res_aborted = 1'b0;
    res_nonce   = '0;
    case (state_q)
      IDLE: begin
        work_ready = 1'b1;
        if (work_valid) state_d = LOAD;
      end
      LOAD: begin
        core_load = 1'b1;
        if (abort || rem_q == '0) state_d = DRAIN;
        else                      state_d = SWEEP;
      end
      SWEEP: begin
        core_issue = 1'b1;
        core_nonce = next_q;
        if (rem_q == CNT_W'(1) || core_hit || abort) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == '0) state_d = REPORT;
      end
      REPORT: begin
        res_valid   = 1'b1;
        res_found   = found_q;
        res_aborted = aborted_q;
        res_nonce   = hit_nonce_q;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign core_midstate = mid_q;
  assign core_data     = data_q;

  // Only the first hit of a work item counts; the core may still report later ones while draining.
  assign hit_take    = (state_q == SWEEP || state_q == DRAIN) && core_hit && !found_q;
  assign enter_drain = (state_d == DRAIN) && (state_q != DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mid_q       <= '0;
      data_q      <= '0;
      next_q      <= '0;
      rem_q       <= '0;
      drain_q     <= '0;
      found_q     <= 1'b0;
      aborted_q   <= 1'b0;
      hit_nonce_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (work_valid) begin
            mid_q       <= work_midstate;
            data_q      <= work_data;
            next_q      <= work_nonce_start;
            rem_q       <= CNT_W'(work_nonce_count);
            found_q     <= 1'b0;
            aborted_q   <= 1'b0;
            hit_nonce_q <= '0;
          end
        end
        LOAD: begin
          if (abort) aborted_q <= 1'b1;
        end
        SWEEP: begin
          next_q <= next_q + 32'd1;
          rem_q  <= rem_q - CNT_W'(1);
          if (abort) aborted_q <= 1'b1;
        end
        REPORT: begin
          if (res_ready) begin
            found_q     <= 1'b0;
            aborted_q   <= 1'b0;
            hit_nonce_q <= '0;
          end
        end
        default: ;
      endcase

      if (hit_take) begin
        found_q     <= 1'b1;
        hit_nonce_q <= core_hit_nonce;
      end

      if (enter_drain) begin
        drain_q <= DRAIN_W'(CORE_LATENCY - 1);
      end else if (state_q == DRAIN && drain_q != '0) begin
        drain_q <= drain_q - DRAIN_W'(1);
      end
    end
  end

endmodule
